// File: rtl/lbm_pkg.sv
// ----------------------------------------------------------------------------
// lbm_pkg
// Shared definitions for the LBM timestep sequencer: lattice geometry,
// counter widths, the externally visible phase code and the internal FSM
// state encoding, plus small helpers that map states onto outputs.
// ----------------------------------------------------------------------------
package lbm_pkg;

    localparam int LBM_NX           = 16;
    localparam int LBM_NY           = 16;
    localparam int LBM_GRID_DIM     = LBM_NX * LBM_NY;
    localparam int LBM_STEP_WIDTH   = 16;
    localparam int LBM_MAX_INFLIGHT = 8;

    // Phase code reported on the phase output.
    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_MACRO   = 2'd1,
        PH_COLLIDE = 2'd2,
        PH_DONE    = 2'd3
    } phase_t;

    // Sequencer states; SWAP is a single-cycle bank/step update.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_MACRO_ISSUE = 3'd1,
        ST_MACRO_DRAIN = 3'd2,
        ST_COLL_ISSUE  = 3'd3,
        ST_COLL_DRAIN  = 3'd4,
        ST_SWAP        = 3'd5,
        ST_DONE        = 3'd6
    } state_t;

    // Phase reported while the FSM sits in a given state.
    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        case (s)
            ST_MACRO_ISSUE, ST_MACRO_DRAIN:         p = PH_MACRO;
            ST_COLL_ISSUE, ST_COLL_DRAIN, ST_SWAP:  p = PH_COLLIDE;
            ST_DONE:                                p = PH_DONE;
            default:                                p = PH_IDLE;
        endcase
        return p;
    endfunction

    // True for the two states that hand cells to the datapath.
    function automatic logic is_issue_state(input state_t s);
        logic r;
        case (s)
            ST_MACRO_ISSUE, ST_COLL_ISSUE: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lbm_xy_counter.sv
// ----------------------------------------------------------------------------
// lbm_xy_counter
// Raster-order cell counter for one lattice sweep. x advances on every
// enable, wrapping NX-1 -> 0 and bumping y. Because NX and NY are powers of
// two the linear address is simply {y, x}, and the whole lattice wraps back
// to cell 0 after the last cell.
// Ports:
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_clear   return to cell 0 (wins over i_enable)
//   i_enable  advance to the next cell
//   o_x/o_y   current column/row
//   o_addr    current linear address y*NX + x
//   o_last    current cell is the final cell of the sweep
// ----------------------------------------------------------------------------
module lbm_xy_counter #(
    parameter int NX = 16,
    parameter int NY = 16,
    parameter int XW = $clog2(NX),
    parameter int YW = $clog2(NY)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_enable,
    output logic [XW-1:0]     o_x,
    output logic [YW-1:0]     o_y,
    output logic [XW+YW-1:0]  o_addr,
    output logic              o_last
);

    localparam logic [XW-1:0] X_LAST = XW'(NX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(NY - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Raster position register: clear to origin, else step x with row carry.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_enable) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= r_y + Y_ONE;
            end else begin
                r_x <= r_x + X_ONE;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = {r_y, r_x};
    assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/lbm_step_sequencer.sv
// ----------------------------------------------------------------------------
// lbm_step_sequencer
// Timestep controller for the LBM core. After start it runs num_steps
// timesteps; each is a MACRO sweep followed by a COLLIDE sweep over every
// lattice cell. Cells are handed out one per valid/ready handshake, returns
// are counted to bound the in-flight window, each sweep drains completely
// before the next begins, and the ping-pong fin bank flips at end of step.
// Ports:
//   CLOCK_50      clock, rising edge
//   RESET         synchronous active-high reset (aborts a run)
//   start         begin a run (sampled in IDLE only)
//   num_steps     timesteps to run, latched on accepted start
//   issue_valid   issue_addr/x/y hold a cell for the datapath
//   issue_ready   datapath accepts the offered cell
//   issue_addr    linear cell address, issue_y*NX + issue_x
//   issue_x/y     cell column/row
//   phase         0 idle, 1 macro, 2 collide, 3 done
//   src_bank      fin bank read this step
//   dst_bank      fin bank written this step
//   ret_valid     datapath retires one cell
//   busy          run in progress
//   done          one-cycle end-of-run pulse
//   step_count    completed timesteps in this run
//   err           sticky: a retire arrived with nothing in flight
// ----------------------------------------------------------------------------
module lbm_step_sequencer
    import lbm_pkg::*;
#(
    parameter int NX            = LBM_NX,
    parameter int NY            = LBM_NY,
    parameter int GRID_DIM      = NX * NY,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
    parameter int STEP_WIDTH    = LBM_STEP_WIDTH,
    parameter int MAX_INFLIGHT  = LBM_MAX_INFLIGHT
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [STEP_WIDTH-1:0]    num_steps,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [ADDRESS_WIDTH-1:0] issue_addr,
    output logic [$clog2(NX)-1:0]    issue_x,
    output logic [$clog2(NY)-1:0]    issue_y,
    output logic [1:0]               phase,
    output logic                     src_bank,
    output logic                     dst_bank,
    input  logic                     ret_valid,
    output logic                     busy,
    output logic                     done,
    output logic [STEP_WIDTH-1:0]    step_count,
    output logic                     err
);

    localparam int IFW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IFW-1:0]        IF_MAX   = IFW'(MAX_INFLIGHT);
    localparam logic [IFW-1:0]        IF_ONE   = IFW'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [IFW-1:0]        r_inflight;
    logic [IFW-1:0]        w_inflight_next;
    logic                  r_issue_valid;
    phase_t                r_phase;
    logic                  r_src_bank;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [STEP_WIDTH-1:0] r_num_steps;
    logic [STEP_WIDTH-1:0] r_step_count;
    logic [STEP_WIDTH-1:0] w_step_next;
    logic                  w_hs;
    logic                  w_underflow;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_drained;

    assign w_hs        = r_issue_valid && issue_ready;
    // A retire that coincides with an issue nets to zero, so only a lone
    // retire at an empty window is an underflow.
    assign w_underflow = ret_valid && !w_hs && (r_inflight == '0);
    assign w_drained   = (r_inflight == '0) && !ret_valid;
    assign w_step_next = r_step_count + STEP_ONE;
    // Restart the raster whenever an issue phase is entered from elsewhere.
    assign w_clear     = is_issue_state(w_next_state) && (w_next_state != r_state);

    lbm_xy_counter #(
        .NX (NX),
        .NY (NY)
    ) u_xy (
        .i_clk    (CLOCK_50),
        .i_rst    (RESET),
        .i_clear  (w_clear),
        .i_enable (w_hs),
        .o_x      (issue_x),
        .o_y      (issue_y),
        .o_addr   (issue_addr),
        .o_last   (w_last)
    );

    // In-flight window update: +1 per issue, -1 per retire, saturating at 0.
    always_comb begin
        w_inflight_next = r_inflight;
        if (w_hs && !ret_valid) begin
            w_inflight_next = r_inflight + IF_ONE;
        end else if (!w_hs && ret_valid && (r_inflight != '0)) begin
            w_inflight_next = r_inflight - IF_ONE;
        end else begin
            w_inflight_next = r_inflight;
        end
    end

    // Next-state selection for the sweep sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (num_steps == '0) ? ST_DONE : ST_MACRO_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MACRO_ISSUE: begin
                if (w_hs && w_last) begin
                    w_next_state = ST_MACRO_DRAIN;
                end else begin
                    w_next_state = ST_MACRO_ISSUE;
                end
            end
            ST_MACRO_DRAIN: begin
                if (w_drained) begin
                    w_next_state = ST_COLL_ISSUE;
                end else begin
                    w_next_state = ST_MACRO_DRAIN;
                end
            end
            ST_COLL_ISSUE: begin
                if (w_hs && w_last) begin
                    w_next_state = ST_COLL_DRAIN;
                end else begin
                    w_next_state = ST_COLL_ISSUE;
                end
            end
            ST_COLL_DRAIN: begin
                if (w_drained) begin
                    w_next_state = ST_SWAP;
                end else begin
                    w_next_state = ST_COLL_DRAIN;
                end
            end
            ST_SWAP: begin
                if (w_step_next == r_num_steps) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_MACRO_ISSUE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, window counter, run bookkeeping and all registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_inflight    <= '0;
            r_issue_valid <= 1'b0;
            r_phase       <= PH_IDLE;
            r_src_bank    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_num_steps   <= '0;
            r_step_count  <= '0;
        end else begin
            r_state       <= w_next_state;
            r_inflight    <= w_inflight_next;
            // Offer a cell only while the window has room after this cycle.
            r_issue_valid <= is_issue_state(w_next_state) && (w_inflight_next < IF_MAX);
            r_phase       <= phase_of(w_next_state);
            r_busy        <= (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);
            r_done        <= (w_next_state == ST_DONE);
            if (w_underflow) begin
                r_err <= 1'b1;
            end
            if ((r_state == ST_IDLE) && start) begin
                r_num_steps  <= num_steps;
                r_step_count <= '0;
            end else if (r_state == ST_SWAP) begin
                r_step_count <= w_step_next;
                r_src_bank   <= ~r_src_bank;
            end
        end
    end

    assign issue_valid = r_issue_valid;
    assign phase       = r_phase;
    assign src_bank    = r_src_bank;
    assign dst_bank    = ~r_src_bank;
    assign busy        = r_busy;
    assign done        = r_done;
    assign step_count  = r_step_count;
    assign err         = r_err;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lbm_step_sequencer
// Randomized bench for the LBM timestep sequencer. A behavioural model
// tracks the handshake index, outstanding cells, error flag and bank; the
// expected cell, phase and bank for handshake k follow from plain
// arithmetic on k. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_lbm_step_sequencer;

    localparam int NX   = 16;
    localparam int GRID = 256;
    localparam int MAXF = 8;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] num_steps = 16'd0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [7:0]  issue_addr;
    logic [3:0]  issue_x;
    logic [3:0]  issue_y;
    logic [1:0]  phase;
    logic        src_bank;
    logic        dst_bank;
    logic        ret_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] step_count;
    logic        err;

    always #5 CLOCK_50 = ~CLOCK_50;

    lbm_step_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .start       (start),
        .num_steps   (num_steps),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_addr  (issue_addr),
        .issue_x     (issue_x),
        .issue_y     (issue_y),
        .phase       (phase),
        .src_bank    (src_bank),
        .dst_bank    (dst_bank),
        .ret_valid   (ret_valid),
        .busy        (busy),
        .done        (done),
        .step_count  (step_count),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int cyc        = 0;
    int m_idx      = 0;   // handshakes accepted in this run
    int m_out      = 0;   // cells issued but not retired
    int m_err      = 0;
    int m_bank     = 0;   // bank at end of last run
    int m_bank0    = 0;   // bank at start of this run
    int m_steps    = 0;
    int peak_out   = 0;
    int done_seen  = 0;
    int last_hs_addr = -1;
    int pend[$];          // cycle numbers at which a retire becomes due
    int ready_mode = 0;   // 0 never, 1 always, 2 random
    int ret_mode   = 0;   // 0 hold, 1 one cycle later, 2 random 1..20
    bit manual_ret = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: compare outputs with the model, then drive the next inputs.
    task automatic tick();
        bit hs;
        bit r;
        int a;
        @(negedge CLOCK_50);
        cyc++;
        chk("err", err, m_err);
        if (issue_valid) chk("valid_room", (m_out < MAXF), 1);
        if (done) begin
            done_seen++;
            chk("done_busy", busy, 0);
            chk("done_phase", phase, 3);
            chk("done_steps", step_count, m_steps);
            chk("done_issues", m_idx, 2 * GRID * m_steps);
            chk("done_bank", src_bank, m_bank0 ^ (m_steps % 2));
        end
        start = 1'b0;
        issue_ready = (ready_mode == 1) || ((ready_mode == 2) && ($urandom_range(1, 0) == 1));
        r = 1'b0;
        if (manual_ret) begin
            r = 1'b1;
            manual_ret = 1'b0;
        end else begin
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i] <= cyc) begin
                    r = 1'b1;
                    pend.delete(i);
                    break;
                end
            end
        end
        ret_valid = r;
        hs = issue_valid && issue_ready;
        if (hs) begin
            a = m_idx % GRID;
            chk("addr", issue_addr, a);
            chk("x", issue_x, a % NX);
            chk("y", issue_y, a / NX);
            chk("phase", phase, ((m_idx / GRID) % 2 == 1) ? 2 : 1);
            chk("src_bank", src_bank, m_bank0 ^ ((m_idx / (2 * GRID)) % 2));
            chk("dst_bank", dst_bank, 1 ^ m_bank0 ^ ((m_idx / (2 * GRID)) % 2));
            chk("busy", busy, 1);
            last_hs_addr = issue_addr;
            m_idx++;
            if (ret_mode == 1) pend.push_back(cyc + 1);
            else if (ret_mode == 2) pend.push_back(cyc + $urandom_range(20, 1));
        end
        if (hs && !r) m_out++;
        else if (!hs && r) begin
            if (m_out == 0) m_err = 1;
            else m_out--;
        end
        if (m_out > peak_out) peak_out = m_out;
    endtask

    task automatic do_reset();
        ready_mode = 0;
        ret_mode = 0;
        RESET = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        ret_valid = 1'b0;
        @(negedge CLOCK_50);
        cyc++;
        RESET = 1'b0;
        m_idx = 0; m_out = 0; m_err = 0; m_bank = 0; peak_out = 0;
        pend.delete();
        chk("rst_valid", issue_valid, 0);
        chk("rst_addr", issue_addr, 0);
        chk("rst_x", issue_x, 0);
        chk("rst_y", issue_y, 0);
        chk("rst_phase", phase, 0);
        chk("rst_src", src_bank, 0);
        chk("rst_dst", dst_bank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_steps", step_count, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic start_run(input int n);
        start = 1'b1;
        num_steps = 16'(n);
        m_steps = n;
        m_idx = 0;
        m_bank0 = m_bank;
        done_seen = 0;
        peak_out = 0;
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (done_seen == 0 && k < budget) begin
            tick();
            k++;
        end
        if (done_seen == 0) chk("run_timeout", 0, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("done_pulses", done_seen, 1);
        m_bank = m_bank0 ^ (m_steps % 2);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge CLOCK_50);
        do_reset();

        // 1: reset in the middle of the collide sweep, right after cell 100
        ready_mode = 1; ret_mode = 1;
        start_run(1);
        k = 0;
        while (m_idx < GRID + 101 && k < 2000) begin tick(); k++; end
        chk("t1_reached", m_idx, GRID + 101);
        chk("t1_phase", phase, 2);
        do_reset();

        // 2: single step, always ready, one-cycle returns
        ready_mode = 1; ret_mode = 1;
        start_run(1);
        run_until_done(3000);
        chk("t2_issues", m_idx, 512);
        chk("t2_steps", step_count, 1);
        chk("t2_bank", src_bank, 1);
        chk("t2_idle_phase", phase, 0);

        // 3: three steps, random ready and random return latency
        do_reset();
        ready_mode = 2; ret_mode = 2;
        start_run(3);
        run_until_done(30000);
        chk("t3_issues", m_idx, 1536);
        chk("t3_peak", (peak_out <= 8), 1);
        chk("t3_steps", step_count, 3);
        chk("t3_bank", src_bank, 1);
        chk("t3_pending", pend.size(), 0);

        // 4: zero steps completes without issuing
        ready_mode = 1; ret_mode = 1;
        start_run(0);
        k = 0;
        while (done_seen == 0 && k < 2) begin tick(); k++; end
        chk("t4_done_fast", done_seen, 1);
        chk("t4_steps", step_count, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_issues", m_idx, 0);
        chk("t4_pulses", done_seen, 1);

        // 5: window fills at 8 and reopens on one return
        do_reset();
        ready_mode = 1; ret_mode = 0;
        start_run(1);
        for (int i = 0; i < 30; i++) tick();
        chk("t5_model_idx", m_idx, 8);
        chk("t5_valid_low", issue_valid, 0);
        chk("t5_addr_held", issue_addr, 8);
        manual_ret = 1'b1;
        k = 0;
        while (m_idx < 9 && k < 10) begin tick(); k++; end
        chk("t5_reissue", last_hs_addr, 8);

        // 6: stray return sets sticky err; start while busy is ignored
        do_reset();
        manual_ret = 1'b1;
        tick();
        tick();
        chk("t6_err", err, 1);
        ready_mode = 1; ret_mode = 1;
        start_run(2);
        for (int i = 0; i < 50; i++) tick();
        start = 1'b1;
        num_steps = 16'd5;
        run_until_done(5000);
        chk("t6_steps", step_count, 2);
        chk("t6_issues", m_idx, 1024);
        chk("t6_err_sticky", err, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_restart", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
